vga_timing_ctrl: RTL and testbench

- Timing controller and update scheduler for the 640x480 VGA pixel path.
- Generates the pixel-rate enable, the pixel_x/pixel_y raster counters consumed by the background and graphics generators, hsync/vsync and video_on.
- Arbitrates writes to displayed data (seconds register/digit RAM) so the seconds-reading state machine updates only during vertical blanking. This prevents tearing.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_ctrl_if.sv | 41 ++++
 rtl/pixel_tick_gen.sv | 35 +++
 rtl/vga_timing_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing controller:
//   - default 640x480@60 timing constants (display, porches, sync widths)
//   - derived totals and sync start/end positions for the default timing
//   - raster coordinate type, scheduler state encoding, range helper
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_TICK_DIV = 2;
    localparam int DEF_HD = 640;
    localparam int DEF_HF = 16;
    localparam int DEF_HB = 48;
    localparam int DEF_HR = 96;
    localparam int DEF_VD = 480;
    localparam int DEF_VF = 10;
    localparam int DEF_VB = 33;
    localparam int DEF_VR = 2;

    localparam int DEF_HT = DEF_HD + DEF_HF + DEF_HB + DEF_HR;
    localparam int DEF_VT = DEF_VD + DEF_VF + DEF_VB + DEF_VR;

    localparam int DEF_HSYNC_START = DEF_HD + DEF_HF;
    localparam int DEF_HSYNC_END   = DEF_HD + DEF_HF + DEF_HR - 1;
    localparam int DEF_VSYNC_START = DEF_VD + DEF_VF;
    localparam int DEF_VSYNC_END   = DEF_VD + DEF_VF + DEF_VR - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        PREEMPT = 2'd2
    } sched_state_t;

    // Inclusive range test on an unsigned raster coordinate.
    function automatic logic in_range(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl_if
// Bundle between the timing controller and its consumers.
//   upd_req      : level request to update displayed data (consumer -> ctrl)
//   p_tick       : one-clk pixel enable
//   pixel_x/y    : raster counters
//   hsync/vsync  : active-low syncs
//   video_on     : inside the visible area
//   frame_start  : one-clk pulse when the raster wraps to (0,0)
//   upd_window   : vertical blank
//   upd_ack      : grant, display data may be written while high
//   upd_abort    : one-clk pulse when a grant is revoked at end of blank
// Modports: master = timing controller, slave = consumer.
// ----------------------------------------------------------------------------
interface vga_timing_ctrl_if;
    import vga_timing_pkg::*;

    logic   upd_req;
    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_start;
    logic   upd_window;
    logic   upd_ack;
    logic   upd_abort;

    modport master (
        input  upd_req,
        output p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
        output frame_start, upd_window, upd_ack, upd_abort
    );

    modport slave (
        output upd_req,
        input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on,
        input  frame_start, upd_window, upd_ack, upd_abort
    );
endinterface

// File: rtl/pixel_tick_gen.sv
// ----------------------------------------------------------------------------
// pixel_tick_gen
// Divides the system clock down to a one-clk pixel enable.
//   clk      : system clock
//   reset    : asynchronous, active-high
//   o_p_tick : high for one clk every TICK_DIV clks (constant 1 when TICK_DIV=1)
// ----------------------------------------------------------------------------
module pixel_tick_gen #(
    parameter int TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic o_p_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // The tick is registered so it is guaranteed low while reset is held,
    // even in the TICK_DIV=1 build where the count never moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_p_tick = r_tick;

endmodule

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
// Raster timing generator and display-update scheduler for the VGA path.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : vga_timing_ctrl_if.master (upd_req in; p_tick, pixel_x, pixel_y,
//           hsync, vsync, video_on, frame_start, upd_window, upd_ack,
//           upd_abort out)
// Display-data writes are granted only during vertical blank so the visible
// picture never tears; a grant still held when blank ends is revoked with a
// one-clk abort pulse and re-issued at the next blank.
// ----------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int HD = DEF_HD,
    parameter int HF = DEF_HF,
    parameter int HB = DEF_HB,
    parameter int HR = DEF_HR,
    parameter int VD = DEF_VD,
    parameter int VF = DEF_VF,
    parameter int VB = DEF_VB,
    parameter int VR = DEF_VR
) (
    input logic              clk,
    input logic              reset,
    vga_timing_ctrl_if.master bus
);
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam int HS_START = HD + HF;
    localparam int HS_END   = HD + HF + HR - 1;
    localparam int VS_START = VD + VF;
    localparam int VS_END   = VD + VF + VR - 1;

    localparam coord_t X_LAST = coord_t'(HT - 1);
    localparam coord_t Y_LAST = coord_t'(VT - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $error("vga_timing_ctrl: TICK_DIV must be >= 1");
        end
        if ((HT - 1 >= 1024) || (VT - 1 >= 1024)) begin : g_bad_geom
            $error("vga_timing_ctrl: raster totals do not fit 10-bit counters");
        end
    endgenerate

    logic         w_p_tick;
    logic         w_x_wrap;
    logic         w_y_wrap;
    coord_t       w_x_next;
    coord_t       w_y_next;
    logic         w_window;
    logic         w_video_on;

    coord_t       r_x;
    coord_t       r_y;
    logic         r_hsync;
    logic         r_vsync;
    logic         r_frame_start;
    logic         r_ack;
    logic         r_abort;
    sched_state_t r_state;

    pixel_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .o_p_tick (w_p_tick)
    );

    always_comb begin
        w_x_wrap = (r_x == X_LAST);
        w_y_wrap = (r_y == Y_LAST);
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            w_x_next = w_x_wrap ? '0 : r_x + coord_t'(1);
            if (w_x_wrap) begin
                w_y_next = w_y_wrap ? '0 : r_y + coord_t'(1);
            end
        end
    end

    // Syncs decode the next counter values so they line up with the
    // registered counters in the same clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= !in_range(w_x_next, HS_START, HS_END);
            r_vsync       <= !in_range(w_y_next, VS_START, VS_END);
            r_frame_start <= w_p_tick && w_x_wrap && w_y_wrap;
        end
    end

    assign w_window   = (r_y >= coord_t'(VD));
    assign w_video_on = (r_x < coord_t'(HD)) && (r_y < coord_t'(VD));

    // Dropping the request wins over the end of blank, so a requester that
    // lets go exactly as blank ends sees no abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.upd_req && w_window) begin
                        r_state <= GRANT;
                        r_ack   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!bus.upd_req) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end else if (!w_window) begin
                        r_state <= PREEMPT;
                        r_ack   <= 1'b0;
                        r_abort <= 1'b1;
                    end
                end
                PREEMPT: begin
                    if (!bus.upd_req) begin
                        r_state <= IDLE;
                    end else if (w_window) begin
                        r_state <= GRANT;
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_tick      = w_p_tick;
    assign bus.pixel_x     = r_x;
    assign bus.pixel_y     = r_y;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.video_on    = w_video_on;
    assign bus.frame_start = r_frame_start;
    assign bus.upd_window  = w_window;
    assign bus.upd_ack     = r_ack;
    assign bus.upd_abort   = r_abort;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Scoreboard bench for vga_timing_ctrl using a reduced raster geometry.
// A driver advances a time-based reference model each clk, pushes the expected
// outputs and drives a random upd_req; a monitor pops and compares at negedge.
// A second instance built with TICK_DIV=1 is checked for a constant pixel
// enable and the frame_start period.
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;
    localparam int TD = 2;
    localparam int HD = 16;
    localparam int HF = 2;
    localparam int HB = 3;
    localparam int HR = 4;
    localparam int VD = 8;
    localparam int VF = 2;
    localparam int VB = 3;
    localparam int VR = 2;
    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic       win;
        logic       ack;
        logic       abort;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    always #5 clk = ~clk;

    vga_timing_ctrl_if vif ();
    vga_timing_ctrl_if vif2 ();

    vga_timing_ctrl #(
        .TICK_DIV(TD), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    vga_timing_ctrl #(
        .TICK_DIV(1), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR)
    ) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (vif2)
    );

    obs_t    exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    bit      run     = 1'b0;
    longint  t       = 0;
    bit      m_ack   = 1'b0;
    int      fs2_pulses = 0;

    // Reference: t clks since reset release. Pixel enables land on clks
    // TD, 2TD, ...; each one moves the raster on at the following edge.
    function automatic obs_t model_at(longint tt, bit ack, bit ab);
        obs_t   o;
        longint n;
        longint pix;
        int     x;
        int     y;
        n   = (tt == 0) ? 0 : (tt - 1) / TD;
        pix = n % FT;
        x   = int'(pix % HT);
        y   = int'(pix / HT);
        o.p_tick = (tt >= TD) && (tt % TD == 0);
        o.x      = 10'(x);
        o.y      = 10'(y);
        o.hs     = !((x >= HD + HF) && (x < HD + HF + HR));
        o.vs     = !((y >= VD + VF) && (y < VD + VF + VR));
        o.von    = (x < HD) && (y < VD);
        o.fs     = (n > 0) && (pix == 0) && ((tt - 1) % TD == 0);
        o.win    = (y >= VD);
        o.ack    = ack;
        o.abort  = ab;
        return o;
    endfunction

    function automatic obs_t sample1();
        obs_t a;
        a.p_tick = vif.p_tick;
        a.x      = vif.pixel_x;
        a.y      = vif.pixel_y;
        a.hs     = vif.hsync;
        a.vs     = vif.vsync;
        a.von    = vif.video_on;
        a.fs     = vif.frame_start;
        a.win    = vif.upd_window;
        a.ack    = vif.upd_ack;
        a.abort  = vif.upd_abort;
        return a;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pt=%0b x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b win=%0b ack=%0b abort=%0b",
                         o.p_tick, o.x, o.y, o.hs, o.vs, o.von, o.fs, o.win, o.ack, o.abort);
    endfunction

    task automatic check_reset(input string tag);
        obs_t a;
        obs_t e;
        a = sample1();
        e.p_tick = 1'b0; e.x = '0; e.y = '0; e.hs = 1'b1; e.vs = 1'b1;
        e.von = 1'b1; e.fs = 1'b0; e.win = 1'b0; e.ack = 1'b0; e.abort = 1'b0;
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", tag, fmt(a), fmt(e));
        end
    endtask

    // Driver: advance the model across the edge just taken, then pick upd_req.
    initial begin : driver
        obs_t cur;
        obs_t nx;
        bit   req;
        bit   ab;
        forever begin
            @(posedge clk);
            #1;
            if (run) begin
                cur   = model_at(t, m_ack, 1'b0);
                req   = vif.upd_req;
                ab    = m_ack && req && !cur.win;
                m_ack = req && cur.win;
                t++;
                nx = model_at(t, m_ack, ab);
                exp_q.push_back(nx);
                if (nx.fs && req) begin
                    // drop exactly as blank ends, or hold on to force a revoke
                    req = ($urandom_range(0, 1) == 1);
                end else if (nx.win && !cur.win && !req) begin
                    req = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, nx.win ? 39 : 149) == 0) begin
                    req = !req;
                end
                vif.upd_req = req;
            end
        end
    end

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample1();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL raster t=%0d: got %s, expected %s", t, fmt(a), fmt(e));
                end
            end
        end
    end

    // TICK_DIV=1 instance: enable always high, frame_start every FT clks,
    // first one FT+1 clks after release.
    initial begin : monitor2
        int     k;
        longint next_fs;
        k = 0;
        next_fs = FT + 1;
        @(negedge reset2);
        @(posedge clk);
        forever begin
            @(negedge clk);
            k++;
            n_tests++;
            if (vif2.p_tick !== 1'b1) begin
                n_fail++;
                $display("FAIL div1_p_tick clk=%0d: got %0b, expected 1", k, vif2.p_tick);
            end
            if (vif2.frame_start === 1'b1) begin
                fs2_pulses++;
                n_tests++;
                if (longint'(k) != next_fs) begin
                    n_fail++;
                    $display("FAIL div1_frame_period: pulse at clk %0d, expected clk %0d", k, next_fs);
                end
                next_fs = longint'(k) + FT;
            end
        end
    end

    initial begin : main
        obs_t probe;
        bit   found;
        vif.upd_req  = 1'b0;
        vif2.upd_req = 1'b0;
        reset  = 1'b1;
        reset2 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_reset("power_on_reset");
        @(posedge clk);
        #3;
        reset  = 1'b0;
        reset2 = 1'b0;
        t      = 0;
        m_ack  = 1'b0;
        run    = 1'b1;

        repeat (8 * FT * TD) @(posedge clk);

        // asynchronous reset in the middle of a visible line
        found = 1'b0;
        for (int i = 0; i < 2 * FT * TD && !found; i++) begin
            @(posedge clk);
            #2;
            probe = model_at(t, 1'b0, 1'b0);
            if (probe.x == 10'd10 && probe.y == 10'd3) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_line_wait: got no x=10 y=3 within bound, expected one");
        end
        run = 1'b0;
        exp_q.delete();
        vif.upd_req = 1'b1;
        reset = 1'b1;
        #1;
        check_reset("mid_line_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_held");
        #2;
        reset = 1'b0;
        t     = 0;
        m_ack = 1'b0;
        run   = 1'b1;

        repeat (3 * FT * TD) @(posedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        n_tests++;
        if (fs2_pulses < 10) begin
            n_fail++;
            $display("FAIL div1_frame_count: got %0d pulses, expected at least 10", fs2_pulses);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
